// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled at bit centre using a shared oversampling tick.
// Good frames pulse rx_done and update rx_data; a low stop bit pulses frame_err instead.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tick,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy,
  output logic [1:0] dbg_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic            rx_meta, rx_s;
  logic [TW-1:0]   tick_cnt, tick_nx;
  logic [2:0]      bit_cnt, bit_nx;
  logic [7:0]      shift, shift_nx;
  logic [7:0]      data_nx;
  logic            done_nx, ferr_nx;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_nx;
      bit_cnt   <= bit_nx;
      shift     <= shift_nx;
      rx_data   <= data_nx;
      rx_done   <= done_nx;
      frame_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    data_nx  = rx_data;
    done_nx  = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          tick_nx  = '0;
          state_nx = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == MID) begin
            if (!rx_s) begin
              state_nx = DATA;
              tick_nx  = '0;
              bit_nx   = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == FULL) begin
            shift_nx = {rx_s, shift[7:1]};
            tick_nx  = '0;
            if (bit_cnt == 3'd7) state_nx = STOP;
            else                 bit_nx   = bit_cnt + 3'd1;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == FULL) begin
            // Strobe and return to IDLE on the same edge; a bad frame leaves rx_data alone.
            if (rx_s) begin
              data_nx = shift;
              done_nx = 1'b1;
            end else begin
              ferr_nx = 1'b1;
            end
            tick_nx  = '0;
            state_nx = IDLE;
          end else begin
            tick_nx = tick_cnt + TW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_busy   = (state != IDLE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bench-side serializer drives frames on the shared tick,
// and a scoreboard of {frame_err, rx_data} entries is checked on every strobe.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int err_seen = 0;
  int tick_div = 10;
  int tcnt = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  logic [7:0] d;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tick      (tick),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy),
    .dbg_state (dbg_state)
  );

  // Clock and tick generation
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tcnt >= tick_div - 1) begin
      tcnt <= 0;
      tick <= 1'b1;
    end else begin
      tcnt <= tcnt + 1;
      tick <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int stop_ticks);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_ticks(16);
    end
    rx = stop_val;
    wait_ticks(stop_ticks);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: pop one expected entry per strobe
  always @(negedge clk) begin
    if (rx_done || frame_err) begin
      checks++;
      assert (!(rx_done && frame_err)) else begin
        errors++;
        $error("FAIL exclusive observed done=%0b err=%0b expected one", rx_done, frame_err);
      end
      checks++;
      assert (!((rx_done && prev_done) || (frame_err && prev_ferr))) else begin
        errors++;
        $error("FAIL strobe_width observed=2+ cycles expected=1 cycle");
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe observed err=%0b data=0x%0h expected=none", frame_err, rx_data);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        assert ({frame_err, rx_data} === exp_v) else begin
          errors++;
          $error("FAIL frame observed err=%0b data=0x%0h expected err=%0b data=0x%0h",
                 frame_err, rx_data, exp_v[8], exp_v[7:0]);
        end
      end
    end
    if (rx_done) done_seen++;
    if (frame_err) err_seen++;
    prev_done = rx_done;
    prev_ferr = frame_err;
  end

  initial begin
    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_done", rx_done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Single frame with slow tick
    exp_q.push_back({1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1, 16);
    wait_drain(4000);
    check("a5_data", rx_data, 8'hA5);
    check("a5_busy", rx_busy, 1'b0);
    check("a5_done_cnt", done_seen, 1);
    check("a5_err_cnt", err_seen, 0);

    // Start glitch shorter than half a bit
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    @(negedge clk);
    check("glitch_busy", rx_busy, 1'b0);
    check("glitch_data", rx_data, 8'hA5);
    check("glitch_done_cnt", done_seen, 1);

    // Bad stop bit after a good byte
    tick_div = 4;
    wait_ticks(2);
    exp_q.push_back({1'b0, 8'h11});
    send_frame(8'h11, 1'b1, 16);
    exp_q.push_back({1'b1, 8'h11});
    send_frame(8'h3C, 1'b0, 12);
    wait_ticks(24);
    wait_drain(2000);
    check("badstop_data", rx_data, 8'h11);
    check("badstop_err_cnt", err_seen, 1);
    check("badstop_done_cnt", done_seen, 2);
    check("badstop_busy", rx_busy, 1'b0);

    // Back-to-back frames with no idle gap
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h00, 1'b1, 16);
    send_frame(8'hFF, 1'b1, 16);
    send_frame(8'h81, 1'b1, 16);
    wait_drain(2000);
    check("b2b_data", rx_data, 8'h81);
    check("b2b_done_cnt", done_seen, 5);

    // Reset during data bit 4 of 0x5A
    d = 8'h5A;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[4];
    wait_ticks(8);
    @(negedge clk);
    check("mid_busy", rx_busy, 1'b1);
    check("mid_state", dbg_state, 2'd2);
    rst = 1'b0;
    #1;
    check("midrst_data", rx_data, 8'h00);
    check("midrst_busy", rx_busy, 1'b0);
    check("midrst_done", rx_done, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_state", dbg_state, 2'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.push_back({1'b0, 8'hC3});
    send_frame(8'hC3, 1'b1, 16);
    wait_drain(2000);
    check("c3_data", rx_data, 8'hC3);
    check("c3_done_cnt", done_seen, 6);

    // Loopback-style stream of all byte values, tick every clock
    tick_div = 1;
    repeat (4) @(posedge clk);
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back({1'b0, 8'(b)});
      send_frame(8'(b), 1'b1, 16);
    end
    wait_drain(2000);
    check("loop_done_cnt", done_seen, 262);
    check("loop_err_cnt", err_seen, 1);
    check("loop_data", rx_data, 8'hFF);
    check("loop_busy", rx_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=no finish expected=finish before limit");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $finish;
  end

endmodule
